fetch_unit: RTL and testbench

- Instruction fetch stage that produces the fields consumed by the control-unit decoder: CU_OPCODE, FUNC3, FUNC7 and the full instruction register.
- Consumes the decoder's PC_SOURCE selection and applies it when the current instruction retires.
- Owns the program counter and runs a req/ack read handshake to instruction memory.
- Sits between the instruction memory and the decoder/execute datapath of the multicycle RISC-V core.

---
 rtl/fetch_unit.sv | 145 ++++++++++++++
 tb/tb_fetch_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage of the multicycle RISC-V core.
// It owns the PC and fetches one instruction at a time with a req/ack read.
// The instruction is held in IR until execute signals ADVANCE. The next PC
// is then chosen by the decoder's PC_SOURCE.
// Ports:
//   CLK, RST           clock (rising edge), asynchronous active-high reset
//   IMEM_ADDR/REQ      instruction read address and held request
//   IMEM_ACK/DATA      acknowledge with same-cycle instruction word
//   PC_SOURCE          0 pc+4, 1 jalr, 2 branch, 3 jal, 4 mtvec, 5 mepc,
//                      6/7 pc+4
//   JALR_ADDR, BRANCH_ADDR, JAL_ADDR, MTVEC, MEPC  candidate targets
//   ADVANCE            current instruction retired; apply PC_SOURCE
//   PC, PC_PLUS4       address of IR and its sequential successor
//   IR, IR_VALID       latched instruction and its valid flag
//   CU_OPCODE, FUNC3, FUNC7  decoder fields sliced from IR
//   MISALIGN           one-cycle pulse after a redirect to an unaligned target
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned XLEN         = 32
) (
  input  logic            CLK,
  input  logic            RST,
  output logic [XLEN-1:0] IMEM_ADDR,
  output logic            IMEM_REQ,
  input  logic            IMEM_ACK,
  input  logic [XLEN-1:0] IMEM_DATA,
  input  logic [2:0]      PC_SOURCE,
  input  logic [XLEN-1:0] JALR_ADDR,
  input  logic [XLEN-1:0] BRANCH_ADDR,
  input  logic [XLEN-1:0] JAL_ADDR,
  input  logic [XLEN-1:0] MTVEC,
  input  logic [XLEN-1:0] MEPC,
  input  logic            ADVANCE,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PC_PLUS4,
  output logic [XLEN-1:0] IR,
  output logic            IR_VALID,
  output logic [6:0]      CU_OPCODE,
  output logic [2:0]      FUNC3,
  output logic [6:0]      FUNC7,
  output logic            MISALIGN
);

  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic {
    FETCH,
    HOLD
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_ir;
  logic            r_ir_valid;
  logic            r_req;
  logic            r_misalign;

  state_t          w_state_nxt;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] w_ir_nxt;
  logic            w_ir_valid_nxt;
  logic            w_req_nxt;
  logic            w_misalign_nxt;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_target;

  assign w_pc_plus4 = r_pc + 32'd4;

  always_comb begin
    w_target = w_pc_plus4;
    case (PC_SOURCE)
      3'd1:    w_target = JALR_ADDR;
      3'd2:    w_target = BRANCH_ADDR;
      3'd3:    w_target = JAL_ADDR;
      3'd4:    w_target = MTVEC;
      3'd5:    w_target = MEPC;
      default: w_target = w_pc_plus4;
    endcase
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_ir_nxt       = r_ir;
    w_ir_valid_nxt = r_ir_valid;
    w_req_nxt      = r_req;
    w_misalign_nxt = 1'b0;
    case (r_state)
      FETCH: begin
        w_req_nxt = 1'b1;
        // An ack counts only once the request is visible on the bus, so a
        // stray ack in the cycle right after reset is discarded.
        if (r_req && IMEM_ACK) begin
          w_ir_nxt       = IMEM_DATA;
          w_ir_valid_nxt = 1'b1;
          w_req_nxt      = 1'b0;
          w_state_nxt    = HOLD;
        end
      end
      HOLD: begin
        w_req_nxt = 1'b0;
        if (ADVANCE) begin
          w_pc_nxt       = {w_target[XLEN-1:2], 2'b00};
          w_misalign_nxt = |w_target[1:0];
          w_ir_valid_nxt = 1'b0;
          // Raise the request on the same edge so that the next fetch can
          // be acked in its first cycle.
          w_req_nxt      = 1'b1;
          w_state_nxt    = FETCH;
        end
      end
      default: w_state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= FETCH;
      r_pc       <= RESET_VECTOR;
      r_ir       <= NOP;
      r_ir_valid <= 1'b0;
      r_req      <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_ir       <= w_ir_nxt;
      r_ir_valid <= w_ir_valid_nxt;
      r_req      <= w_req_nxt;
      r_misalign <= w_misalign_nxt;
    end
  end

  assign IMEM_ADDR = r_pc;
  assign IMEM_REQ  = r_req;
  assign PC        = r_pc;
  assign PC_PLUS4  = w_pc_plus4;
  assign IR        = r_ir;
  assign IR_VALID  = r_ir_valid;
  assign CU_OPCODE = r_ir[6:0];
  assign FUNC3     = r_ir[14:12];
  assign FUNC7     = r_ir[31:25];
  assign MISALIGN  = r_misalign;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_REQ;
  logic        IMEM_ACK;
  logic [31:0] IMEM_DATA;
  logic [2:0]  PC_SOURCE;
  logic [31:0] JALR_ADDR, BRANCH_ADDR, JAL_ADDR, MTVEC, MEPC;
  logic        ADVANCE;
  logic [31:0] PC, PC_PLUS4, IR;
  logic        IR_VALID;
  logic [6:0]  CU_OPCODE;
  logic [2:0]  FUNC3;
  logic [6:0]  FUNC7;
  logic        MISALIGN;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 CLK = ~CLK;

  fetch_unit #(.RESET_VECTOR(32'h0000_0000), .XLEN(32)) dut (
    .CLK(CLK), .RST(RST),
    .IMEM_ADDR(IMEM_ADDR), .IMEM_REQ(IMEM_REQ),
    .IMEM_ACK(IMEM_ACK), .IMEM_DATA(IMEM_DATA),
    .PC_SOURCE(PC_SOURCE),
    .JALR_ADDR(JALR_ADDR), .BRANCH_ADDR(BRANCH_ADDR), .JAL_ADDR(JAL_ADDR),
    .MTVEC(MTVEC), .MEPC(MEPC),
    .ADVANCE(ADVANCE),
    .PC(PC), .PC_PLUS4(PC_PLUS4), .IR(IR), .IR_VALID(IR_VALID),
    .CU_OPCODE(CU_OPCODE), .FUNC3(FUNC3), .FUNC7(FUNC7),
    .MISALIGN(MISALIGN)
  );

  typedef struct {
    logic [2:0]  src;
    logic [31:0] jalr;
    logic [31:0] br;
    logic [31:0] jal;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic [31:0] exp_pc;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one clock and settle just past the active edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Unused targets carry an unaligned distractor so a wrong mux leg shows
  // up both in PC and in MISALIGN.
  function automatic vec_t mk(input logic [2:0] src, input logic [31:0] tgt,
                              input logic [31:0] exp_pc, input logic exp_mis);
    vec_t v;
    v.src   = src;
    v.jalr  = 32'hDEAD_BEE1;
    v.br    = 32'hDEAD_BEE1;
    v.jal   = 32'hDEAD_BEE1;
    v.mtvec = 32'hDEAD_BEE1;
    v.mepc  = 32'hDEAD_BEE1;
    case (src)
      3'd1: v.jalr  = tgt;
      3'd2: v.br    = tgt;
      3'd3: v.jal   = tgt;
      3'd4: v.mtvec = tgt;
      3'd5: v.mepc  = tgt;
      default: ;
    endcase
    v.exp_pc  = exp_pc;
    v.exp_mis = exp_mis;
    return v;
  endfunction

  initial begin
    // Table starts from PC = 8; each row's expectation chains off the last.
    vecs[0] = mk(3'd3, 32'h0000_0100, 32'h0000_0100, 1'b0);
    vecs[1] = mk(3'd5, 32'h0000_0080, 32'h0000_0080, 1'b0);
    vecs[2] = mk(3'd7, 32'h0,         32'h0000_0084, 1'b0);
    vecs[3] = mk(3'd6, 32'h0,         32'h0000_0088, 1'b0);
    vecs[4] = mk(3'd2, 32'h0000_0300, 32'h0000_0300, 1'b0);
    vecs[5] = mk(3'd4, 32'h0000_1000, 32'h0000_1000, 1'b0);
    vecs[6] = mk(3'd1, 32'h0000_0203, 32'h0000_0200, 1'b1);
    vecs[7] = mk(3'd4, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0);
    vecs[8] = mk(3'd0, 32'h0,         32'h0000_0000, 1'b0);
    vecs[9] = mk(3'd2, 32'h0000_0041, 32'h0000_0040, 1'b1);

    RST = 1'b1;
    IMEM_ACK = 1'b0; IMEM_DATA = '0; PC_SOURCE = '0; ADVANCE = 1'b0;
    JALR_ADDR = '0; BRANCH_ADDR = '0; JAL_ADDR = '0; MTVEC = '0; MEPC = '0;

    // Reset held for three cycles.
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rst_req_c%0d", i), {31'b0, IMEM_REQ}, 32'd0);
    end
    check("rst_pc", PC, 32'h0);
    check("rst_ir", IR, 32'h13);
    check("rst_irv", {31'b0, IR_VALID}, 32'd0);
    check("rst_mis", {31'b0, MISALIGN}, 32'd0);
    RST = 1'b0;

    step();
    check("rel_req", {31'b0, IMEM_REQ}, 32'd1);
    check("rel_addr", IMEM_ADDR, 32'h0);
    check("rel_ir", IR, 32'h13);
    check("rel_irv", {31'b0, IR_VALID}, 32'd0);

    // Sequential fetch, zero wait states.
    IMEM_ACK = 1'b1; IMEM_DATA = 32'h0050_0093;
    step();
    IMEM_ACK = 1'b0;
    check("seq_irv", {31'b0, IR_VALID}, 32'd1);
    check("seq_ir", IR, 32'h0050_0093);
    check("seq_opc", {25'b0, CU_OPCODE}, 32'h13);
    check("seq_f3", {29'b0, FUNC3}, 32'h0);
    check("seq_f7", {25'b0, FUNC7}, 32'h0);
    check("seq_req_hold", {31'b0, IMEM_REQ}, 32'd0);
    check("seq_pc4", PC_PLUS4, 32'h4);
    ADVANCE = 1'b1; PC_SOURCE = 3'd0;
    step();
    ADVANCE = 1'b0;
    check("seq_pc", PC, 32'h4);
    check("seq_addr", IMEM_ADDR, 32'h4);
    check("seq_req", {31'b0, IMEM_REQ}, 32'd1);
    check("seq_irv_clr", {31'b0, IR_VALID}, 32'd0);

    // Five wait states; ADVANCE during FETCH must be ignored.
    ADVANCE = 1'b1; PC_SOURCE = 3'd3; JAL_ADDR = 32'h500;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("ws_req_c%0d", i), {31'b0, IMEM_REQ}, 32'd1);
      check($sformatf("ws_addr_c%0d", i), IMEM_ADDR, 32'h4);
    end
    ADVANCE = 1'b0;
    IMEM_ACK = 1'b1; IMEM_DATA = 32'h4020_81B3;
    step();
    check("ws_ir", IR, 32'h4020_81B3);
    check("ws_opc", {25'b0, CU_OPCODE}, 32'h33);
    check("ws_f7", {25'b0, FUNC7}, 32'h20);
    // Ack pulse while holding must not disturb IR.
    IMEM_DATA = 32'hFFFF_FFFF;
    step();
    IMEM_ACK = 1'b0;
    check("hold_ack_ir", IR, 32'h4020_81B3);
    check("hold_ack_irv", {31'b0, IR_VALID}, 32'd1);
    check("hold_ack_req", {31'b0, IMEM_REQ}, 32'd0);
    check("hold_ack_pc", PC, 32'h4);
    ADVANCE = 1'b1; PC_SOURCE = 3'd0;
    step();
    ADVANCE = 1'b0;
    check("ws_next_pc", PC, 32'h8);

    // Redirect table: fetch, then retire with the row's PC_SOURCE.
    for (int i = 0; i < 10; i++) begin
      IMEM_ACK = 1'b1; IMEM_DATA = 32'h0000_0013 + (i << 7);
      step();
      IMEM_ACK = 1'b0;
      check($sformatf("v%0d_irv", i), {31'b0, IR_VALID}, 32'd1);
      check($sformatf("v%0d_ir", i), IR, 32'h0000_0013 + (i << 7));
      PC_SOURCE = vecs[i].src;
      JALR_ADDR = vecs[i].jalr; BRANCH_ADDR = vecs[i].br;
      JAL_ADDR = vecs[i].jal; MTVEC = vecs[i].mtvec; MEPC = vecs[i].mepc;
      ADVANCE = 1'b1;
      step();
      ADVANCE = 1'b0;
      check($sformatf("v%0d_pc", i), PC, vecs[i].exp_pc);
      check($sformatf("v%0d_addr", i), IMEM_ADDR, vecs[i].exp_pc);
      check($sformatf("v%0d_mis", i), {31'b0, MISALIGN}, {31'b0, vecs[i].exp_mis});
      check($sformatf("v%0d_req", i), {31'b0, IMEM_REQ}, 32'd1);
      step();
      check($sformatf("v%0d_mis_end", i), {31'b0, MISALIGN}, 32'd0);
    end

    // Reset mid-fetch at PC = 0x40, with an ack arriving during reset.
    check("mid_pre_pc", PC, 32'h40);
    check("mid_pre_req", {31'b0, IMEM_REQ}, 32'd1);
    RST = 1'b1;
    #1;
    check("mid_req", {31'b0, IMEM_REQ}, 32'd0);
    check("mid_pc", PC, 32'h0);
    check("mid_irv", {31'b0, IR_VALID}, 32'd0);
    check("mid_ir", IR, 32'h13);
    IMEM_ACK = 1'b1; IMEM_DATA = 32'h1234_5678;
    step();
    check("mid_ack_ir", IR, 32'h13);
    check("mid_ack_irv", {31'b0, IR_VALID}, 32'd0);
    IMEM_ACK = 1'b0;
    RST = 1'b0;
    step();
    check("post_req", {31'b0, IMEM_REQ}, 32'd1);
    check("post_addr", IMEM_ADDR, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
